ffnn_layer_engine: RTL and testbench

Parametrised, handshaked single-layer feed-forward engine: N_IN signed inputs × N_OUT weight rows held in an internal weight RAM, one neuron's dot product per cycle, ternary threshold activation. Successor to the fixed 4-input/6-neuron layer datapath; adds a runtime weight-load port, valid/ready handshakes, configurable dimensions and threshold, and optional per-neuron bias. Sits between the input sample source and the next layer or decision logic.

---
 rtl/ffnn_pkg.sv | 23 ++
 rtl/ffnn_layer_engine_if.sv | 39 +++
 rtl/ffnn_ternary_act.sv | 25 ++
 rtl/ffnn_layer_engine.sv | 116 +++++++++++
 tb/tb_ffnn_layer_engine.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ffnn_pkg.sv
// Shared encodings and sizing helpers for the feed-forward layer engine.
// Optional per-neuron bias is enabled by defining FFNN_BIAS_EN.
package ffnn_pkg;

   localparam logic [1:0] TERN_POS  = 2'b01;
   localparam logic [1:0] TERN_ZERO = 2'b00;
   localparam logic [1:0] TERN_NEG  = 2'b11;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Sized so that the full dot product (plus bias) can never wrap.
   function automatic int ffnn_accw(
      input int xw,
      input int ww,
      input int n_in,
      input bit bias
   );
      return xw + ww + $clog2(n_in) + 1 + int'(bias);
   endfunction

endpackage

// File: rtl/ffnn_layer_engine_if.sv
// Sample, result and weight-load handshakes of the layer engine.
// wl_data gains a top bias field when FFNN_BIAS_EN is defined.
interface ffnn_layer_engine_if #(
   parameter int N_IN   = 4,
   parameter int N_OUT  = 6,
   parameter int XWIDTH = 9,
   parameter int WWIDTH = 8
) ();

   localparam int AW = $clog2(N_OUT);
`ifdef FFNN_BIAS_EN
   localparam int RW = N_IN * WWIDTH + XWIDTH + WWIDTH;
`else
   localparam int RW = N_IN * WWIDTH;
`endif

   logic                     in_valid;
   logic                     in_ready;
   logic [N_IN*XWIDTH-1:0]   in_x;
   logic                     out_valid;
   logic                     out_ready;
   logic [2*N_OUT-1:0]       out_y;
   logic                     wl_en;
   logic [AW-1:0]            wl_addr;
   logic [RW-1:0]            wl_data;

   modport master (
      output in_valid, in_x, out_ready,
      output wl_en, wl_addr, wl_data,
      input  in_ready, out_valid, out_y
   );

   modport slave (
      input  in_valid, in_x, out_ready,
      input  wl_en, wl_addr, wl_data,
      output in_ready, out_valid, out_y
   );

endinterface

// File: rtl/ffnn_ternary_act.sv
// Ternary threshold activation: acc >= T -> +1, acc <= -T -> -1, else 0.
// Purely combinational.
module ffnn_ternary_act
   import ffnn_pkg::*;
#(
   parameter int ACCW   = 20,
   parameter int THRESH = 2
) (
   input  logic signed [ACCW-1:0] acc,
   output logic        [1:0]      y
);

   localparam logic signed [ACCW-1:0] POS = ACCW'(THRESH);
   localparam logic signed [ACCW-1:0] NEG = -POS;

   always_comb begin
      y = TERN_ZERO;
      unique case (1'b1)
         (acc >= POS): y = TERN_POS;
         (acc <= NEG): y = TERN_NEG;
         default:      y = TERN_ZERO;
      endcase
   end

endmodule

// File: rtl/ffnn_layer_engine.sv
// Single-layer feed-forward engine, one neuron per cycle from weight RAM.
// Define FFNN_BIAS_EN to add a signed per-row bias to each accumulator.
module ffnn_layer_engine
   import ffnn_pkg::*;
#(
   parameter int N_IN   = 4,
   parameter int N_OUT  = 6,
   parameter int XWIDTH = 9,
   parameter int WWIDTH = 8,
   parameter int THRESH = 2
) (
   input  logic                CLK,
   input  logic                RST,
   ffnn_layer_engine_if.slave  bus,
   output logic                busy
);

   localparam int AW = $clog2(N_OUT);
   localparam int CW = $clog2(N_OUT + 1);
   localparam int BWIDTH = XWIDTH + WWIDTH;
`ifdef FFNN_BIAS_EN
   localparam bit HAS_B = 1'b1;
   localparam int RW = N_IN * WWIDTH + BWIDTH;
`else
   localparam bit HAS_B = 1'b0;
   localparam int RW = N_IN * WWIDTH;
`endif
   localparam int ACCW = ffnn_accw(XWIDTH, WWIDTH, N_IN, HAS_B);

   logic [1:0]               state;
   logic [CW-1:0]            cnt;
   logic [N_IN*XWIDTH-1:0]   x_q;
   logic [2*N_OUT-1:0]       y_q;
   logic [RW-1:0]            rd_q;
   logic [RW-1:0]            ram [N_OUT];

   logic signed [ACCW-1:0]   acc;
   logic signed [ACCW-1:0]   xe;
   logic signed [ACCW-1:0]   we;
   logic [1:0]               act;
   logic                     wr_ok;
   logic                     rd_ok;

   assign bus.in_ready  = (state == S_IDLE);
   assign bus.out_valid = (state == S_DONE);
   assign bus.out_y     = y_q;
   assign busy          = (state == S_RUN);

   assign wr_ok = (state == S_IDLE) && bus.wl_en
                  && (int'(bus.wl_addr) < N_OUT);
   assign rd_ok = (state == S_RUN) && (int'(cnt) < N_OUT);

   // RAM contents survive reset; row read lands one cycle after issue.
   always_ff @(posedge CLK) begin
      if (wr_ok)
         ram[bus.wl_addr] <= bus.wl_data;
      if (rd_ok)
         rd_q <= ram[AW'(cnt)];
   end

   always_comb begin
      acc = '0;
      xe  = '0;
      we  = '0;
      for (int i = 0; i < N_IN; i++) begin
         xe  = ACCW'(signed'(x_q[i*XWIDTH +: XWIDTH]));
         we  = ACCW'(signed'(rd_q[i*WWIDTH +: WWIDTH]));
         acc = acc + xe * we;
      end
`ifdef FFNN_BIAS_EN
      acc = acc + ACCW'(signed'(rd_q[N_IN*WWIDTH +: BWIDTH]));
`endif
   end

   ffnn_ternary_act #(
      .ACCW   (ACCW),
      .THRESH (THRESH)
   ) u_act (
      .acc (acc),
      .y   (act)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= S_IDLE;
         cnt   <= '0;
         x_q   <= '0;
         y_q   <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  x_q   <= bus.in_x;
                  cnt   <= '0;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               cnt <= cnt + CW'(1);
               // cnt-1 is the row whose read data is now in rd_q
               for (int j = 0; j < N_OUT; j++)
                  if (cnt == CW'(j + 1))
                     y_q[2*j +: 2] <= act;
               if (cnt == CW'(N_OUT))
                  state <= S_DONE;
            end
            S_DONE: begin
               if (bus.out_ready)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ffnn_layer_engine.sv
// Scoreboard bench for ffnn_layer_engine; define FFNN_BIAS_EN
// to also exercise the bias field.
module tb_ffnn_layer_engine;

   localparam int N_IN = 4;
   localparam int N_OUT = 6;
   localparam int XW = 9;
   localparam int WW = 8;
   localparam int TH = 2;
   localparam int AW = $clog2(N_OUT);
   localparam int BW = XW + WW;
`ifdef FFNN_BIAS_EN
   localparam int RW = N_IN * WW + BW;
`else
   localparam int RW = N_IN * WW;
`endif

   logic CLK = 1'b0;
   logic RST = 1'b0;
   logic busy;

   always #5 CLK = ~CLK;

   ffnn_layer_engine_if #(
      .N_IN(N_IN), .N_OUT(N_OUT), .XWIDTH(XW), .WWIDTH(WW)
   ) bus ();

   ffnn_layer_engine #(
      .N_IN(N_IN), .N_OUT(N_OUT), .XWIDTH(XW),
      .WWIDTH(WW), .THRESH(TH)
   ) dut (
      .CLK  (CLK),
      .RST  (RST),
      .bus  (bus),
      .busy (busy)
   );

   int total = 0;
   int bad = 0;
   logic [2*N_OUT-1:0] exp_q[$];
   int w_m [N_OUT][N_IN];
   int b_m [N_OUT];

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [N_IN*XW-1:0] pack_x(input int x[N_IN]);
      logic [N_IN*XW-1:0] v;
      v = '0;
      for (int i = 0; i < N_IN; i++) v[i*XW +: XW] = XW'(x[i]);
      return v;
   endfunction

   function automatic logic [RW-1:0] pack_row(input int w[N_IN],
                                               input int b);
      logic [RW-1:0] v;
      v = '0;
      for (int i = 0; i < N_IN; i++) v[i*WW +: WW] = WW'(w[i]);
`ifdef FFNN_BIAS_EN
      v[N_IN*WW +: BW] = BW'(b);
`else
      if (b != 0) $display("note: bias ignored in this build");
`endif
      return v;
   endfunction

   function automatic logic [2*N_OUT-1:0] model(input int x[N_IN]);
      logic [2*N_OUT-1:0] y;
      longint acc;
      y = '0;
      for (int j = 0; j < N_OUT; j++) begin
         acc = b_m[j];
         for (int i = 0; i < N_IN; i++) acc += x[i] * w_m[j][i];
         if (acc >= TH) y[2*j +: 2] = 2'b01;
         else if (acc <= -TH) y[2*j +: 2] = 2'b11;
         else y[2*j +: 2] = 2'b00;
      end
      return y;
   endfunction

   task automatic load_row(input int row, input int w[N_IN],
                           input int b);
      @(negedge CLK);
      bus.wl_en = 1'b1;
      bus.wl_addr = AW'(row);
      bus.wl_data = pack_row(w, b);
      @(negedge CLK);
      bus.wl_en = 1'b0;
      if (row < N_OUT) begin
         w_m[row] = w;
`ifdef FFNN_BIAS_EN
         b_m[row] = b;
`endif
      end
   endtask

   task automatic run_sample(input int x[N_IN], input int hold,
                             input bit wl_run, input bit wl_same,
                             input int ww[N_IN]);
      logic [2*N_OUT-1:0] y0;
      int n;
      @(negedge CLK);
      chk("in_ready_idle", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_x = pack_x(x);
      if (wl_same) begin
         bus.wl_en = 1'b1;
         bus.wl_addr = AW'(1);
         bus.wl_data = pack_row(ww, 0);
         w_m[1] = ww;
         b_m[1] = 0;
      end
      exp_q.push_back(model(x));
      @(posedge CLK);
      #1;
      bus.in_valid = 1'b0;
      bus.wl_en = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 40) begin
         if (wl_run && n == 2) begin
            bus.wl_en = 1'b1;
            bus.wl_addr = AW'(3);
            bus.wl_data = pack_row(ww, 0);
         end else begin
            bus.wl_en = 1'b0;
         end
         @(posedge CLK);
         #1;
         n++;
         if (n == 1) begin
            chk("busy_run", busy, 1);
            chk("in_ready_run", bus.in_ready, 0);
         end
      end
      bus.wl_en = 1'b0;
      chk("latency", n, N_OUT + 1);
      y0 = bus.out_y;
      repeat (hold) begin
         @(posedge CLK);
         #1;
         chk("y_stable", bus.out_y, y0);
         chk("in_ready_done", bus.in_ready, 0);
         chk("valid_held", bus.out_valid, 1);
      end
      @(negedge CLK);
      bus.out_ready = 1'b1;
      if (exp_q.size() > 0) chk("y", bus.out_y, exp_q.pop_front());
      @(posedge CLK);
      #1;
      bus.out_ready = 1'b0;
      chk("back_idle", bus.in_ready, 1);
      chk("valid_drop", bus.out_valid, 0);
   endtask

   int xv[N_IN];
   int wv[N_IN];
   int wz[N_IN];
   int tv[4] = '{1, 2, -2, -1};
   logic [1:0] te[4] = '{2'b00, 2'b01, 2'b11, 2'b00};

   initial begin
      #2_000_000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.in_x = '0;
      bus.out_ready = 1'b0;
      bus.wl_en = 1'b0;
      bus.wl_addr = '0;
      bus.wl_data = '0;
      for (int j = 0; j < N_OUT; j++) b_m[j] = 0;
      wz = '{0, 0, 0, 0};
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_y", bus.out_y, 0);
      chk("rst_busy", busy, 0);
      @(negedge CLK);
      RST = 1'b1;

      wv = '{1, 0, 0, 0};
      load_row(0, wv, 0);
      for (int j = 1; j < N_OUT; j++) begin
         for (int i = 0; i < N_IN; i++)
            wv[i] = int'($urandom_range(0, 255)) - 128;
         load_row(j, wv, 0);
      end

      for (int k = 0; k < 4; k++) begin
         xv = '{tv[k], 0, 0, 0};
         run_sample(xv, 0, 1'b0, 1'b0, wz);
         chk("thr_slot0", bus.out_y[1:0], te[k]);
      end

      wv = '{-128, -128, -128, -128};
      for (int j = 0; j < N_OUT; j++) load_row(j, wv, 0);
      xv = '{-256, -256, -256, -256};
      run_sample(xv, 0, 1'b0, 1'b0, wz);
      chk("ext_pos", bus.out_y, 12'h555);
      wv = '{127, 127, 127, 127};
      for (int j = 0; j < N_OUT; j++) load_row(j, wv, 0);
      run_sample(xv, 0, 1'b0, 1'b0, wz);
      chk("ext_neg", bus.out_y, 12'hfff);

      for (int j = 0; j < N_OUT; j++) begin
         for (int i = 0; i < N_IN; i++)
            wv[i] = int'($urandom_range(0, 40)) - 20;
         load_row(j, wv, 0);
      end
      xv = '{37, -12, 5, -90};
      run_sample(xv, 10, 1'b0, 1'b0, wz);

      wv = '{127, 127, 127, 127};
      xv = '{-50, -50, -50, -50};
      run_sample(xv, 0, 1'b1, 1'b0, wv);

      load_row(7, wv, 0);
      run_sample(xv, 0, 1'b0, 1'b0, wz);

      wv = '{-100, -100, -100, -100};
      xv = '{3, 3, 3, 3};
      run_sample(xv, 0, 1'b0, 1'b1, wv);
      chk("same_row1", bus.out_y[3:2], 2'b11);

      @(negedge CLK);
      bus.in_valid = 1'b1;
      bus.in_x = pack_x(xv);
      @(posedge CLK);
      #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      chk("mid_in_ready", bus.in_ready, 1);
      chk("mid_out_valid", bus.out_valid, 0);
      chk("mid_out_y", bus.out_y, 0);
      @(posedge CLK);
      #1;
      chk("mid_busy", busy, 0);
      @(negedge CLK);
      RST = 1'b1;
      run_sample(xv, 0, 1'b0, 1'b0, wz);

      repeat (4) begin
         for (int i = 0; i < N_IN; i++)
            xv[i] = int'($urandom_range(0, 511)) - 256;
         run_sample(xv, 0, 1'b0, 1'b0, wz);
      end

`ifdef FFNN_BIAS_EN
      load_row(0, wz, 2);
      xv = '{11, 22, 33, 44};
      run_sample(xv, 0, 1'b0, 1'b0, wz);
      chk("bias_pos", bus.out_y[1:0], 2'b01);
      load_row(0, wz, -1);
      run_sample(xv, 0, 1'b0, 1'b0, wz);
      chk("bias_zero", bus.out_y[1:0], 2'b00);
      load_row(0, wz, -5);
      run_sample(xv, 0, 1'b0, 1'b0, wz);
      chk("bias_neg", bus.out_y[1:0], 2'b11);
`endif

      chk("sb_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
